// File: rtl/motor_pkg.sv
// Shared motion-control definitions: direction encoding, axis FSM states and
// coil lookup tables used by the stepper axis driver and the motion controller.
package motor_pkg;

  localparam logic [1:0] DIR_STOP  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DWELL = 2'd2
  } axis_state_t;

  // 2'b11 is deliberately not a direction: it must never produce motion.
  function automatic logic is_move(input logic [1:0] d);
    return (d == DIR_LEFT) || (d == DIR_RIGHT);
  endfunction

  function automatic logic [3:0] full_coil(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b1100;
      2'd1:    return 4'b0110;
      2'd2:    return 4'b0011;
      default: return 4'b1001;
    endcase
  endfunction

  function automatic logic [3:0] half_coil(input logic [2:0] idx);
    case (idx)
      3'd0:    return 4'b1000;
      3'd1:    return 4'b1100;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b0010;
      3'd5:    return 4'b0011;
      3'd6:    return 4'b0001;
      default: return 4'b1001;
    endcase
  endfunction

endpackage

// File: rtl/stepper_axis_driver_step_rate_divider.sv
// Step timer: counts 0..STEP_DIV-1 and raises tick on the terminal count;
// clear holds the count at zero.
module step_rate_divider #(
  parameter int STEP_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !clear && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stepper_axis_driver.sv
// Single-axis unipolar stepper driver: direction command in, timed coil
// patterns, step strobe and wrapped position out. Define HALF_STEP_EN for half-stepping.
module stepper_axis_driver
  import motor_pkg::*;
#(
  parameter int STEP_DIV  = 50000,
  parameter int DWELL_CYC = 5000,
  parameter int POS_MAX   = 360
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  dir_cmd,
  input  logic        pos_load,
  input  logic [15:0] pos_load_val,
  output logic [3:0]  coils,
  output logic [15:0] pos,
  output logic        step_pulse,
  output logic        moving
);

`ifdef HALF_STEP_EN
  localparam int IDX_W = 3;
  function automatic logic [3:0] coil_of(input logic [IDX_W-1:0] i);
    return half_coil(i);
  endfunction
`else
  localparam int IDX_W = 2;
  function automatic logic [3:0] coil_of(input logic [IDX_W-1:0] i);
    return full_coil(i);
  endfunction
`endif

  localparam int DW_W = $clog2(DWELL_CYC + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_CYC - 1);
  localparam logic [15:0] POS_LAST = 16'(POS_MAX - 1);

  function automatic logic [15:0] pos_clamp(input logic [15:0] v);
    return (v > POS_LAST) ? POS_LAST : v;
  endfunction

  function automatic logic [15:0] pos_wrap_step(input logic [15:0] p, input logic right);
    if (right) return (p >= POS_LAST) ? 16'd0 : p + 16'd1;
    else       return (p == 16'd0) ? POS_LAST : p - 16'd1;
  endfunction

  axis_state_t       state;
  logic [1:0]        dir_q;
  logic [IDX_W-1:0]  idx;
  logic [DW_W-1:0]   dwell_cnt;
  logic              stay_run;
  logic              step;
  logic [IDX_W-1:0]  idx_nxt;
  logic [15:0]       pos_nxt;
  logic [3:0]        coils_nxt;

  // The timer only runs while RUN is kept; stopping, reversing or disabling
  // clears it on the same edge so no partial step is ever emitted.
  assign stay_run = (state == RUN) && enable && (dir_cmd == dir_q);

  step_rate_divider #(
    .STEP_DIV (STEP_DIV)
  ) u_step_div (
    .clk   (clk),
    .rst   (rst),
    .clear (!stay_run),
    .tick  (step)
  );

  always_comb begin
    idx_nxt = idx;
    if (step) idx_nxt = (dir_q == DIR_RIGHT) ? idx + IDX_W'(1) : idx - IDX_W'(1);
    pos_nxt = pos;
    if (pos_load)  pos_nxt = pos_clamp(pos_load_val);
    else if (step) pos_nxt = pos_wrap_step(pos, dir_q == DIR_RIGHT);
    coils_nxt = enable ? coil_of(idx_nxt) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      dir_q      <= DIR_STOP;
      idx        <= '0;
      dwell_cnt  <= '0;
      pos        <= '0;
      coils      <= 4'b0000;
      step_pulse <= 1'b0;
      moving     <= 1'b0;
    end else begin
      idx        <= idx_nxt;
      pos        <= pos_nxt;
      coils      <= coils_nxt;
      step_pulse <= step;
      case (state)
        IDLE: begin
          if (enable && is_move(dir_cmd)) begin
            state  <= RUN;
            dir_q  <= dir_cmd;
            moving <= 1'b1;
          end
        end
        RUN: begin
          if (!enable || !is_move(dir_cmd)) begin
            state  <= IDLE;
            moving <= 1'b0;
          end else if (dir_cmd != dir_q) begin
            state     <= DWELL;
            dwell_cnt <= '0;
            moving    <= 1'b0;
          end
        end
        DWELL: begin
          if (!enable) begin
            state <= IDLE;
          end else if (dwell_cnt == DWELL_LAST) begin
            if (is_move(dir_cmd)) begin
              state  <= RUN;
              dir_q  <= dir_cmd;
              moving <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            dwell_cnt <= dwell_cnt + DW_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          moving <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/stepper_axis_driver.md
Name: stepper_axis_driver

Overview:
- Downstream stage of the tracker motion controller: consumes one axis' 2-bit direction command (teta or fi) and drives a 4-coil unipolar stepper.
- Produces timed coil phase patterns and a single-cycle step strobe.
- Maintains the axis position counter (degrees, wrap at 360) that is fed back to the controller as teta_actual/fi_actual.
- One instance per axis.

Parameters:
- STEP_DIV, 50000, clk cycles between step events while running (>=2).
- DWELL_CYC, 5000, stationary hold cycles inserted on direction reversal (>=1).
- POS_MAX, 360, position modulus; pos range 0..POS_MAX-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  1 = driver active; 0 = coils de-energised, position retained.
- dir_cmd  in  2  2'b01 = move left (pos decrements); 2'b10 = move right (pos increments); 2'b00 or 2'b11 = stop.
- pos_load  in  1  one-cycle strobe: overwrite position.
- pos_load_val  in  16  value loaded into pos.
- coils  out  4  coil drive pattern, registered.
- pos  out  16  current axis position, registered.
- step_pulse  out  1  high exactly one cycle per step event.
- moving  out  1  high in RUN state.

Behaviour:
- Reset (async): state=IDLE, phase index=0, divider=0, dwell counter=0, pos=0, coils=4'b0000, step_pulse=0, moving=0.
- Full-step coil table, index 0..3: 1100, 0110, 0011, 1001.
  - Right: index+1 mod 4. Left: index-1 mod 4.
- FSM states: IDLE, RUN, DWELL. Latched run direction dir_q.
- IDLE:
  - coils = table[index] if enable=1, else 0000. Divider held at 0.
  - dir_cmd in {01,10} and enable=1 -> RUN; dir_q <= dir_cmd.
- RUN:
  - Divider counts 0..STEP_DIV-1. At terminal count, in the same edge: step event, index update, pos update, step_pulse=1, divider back to 0.
  - First step_pulse occurs STEP_DIV cycles after the first RUN cycle.
  - dir_cmd stop -> IDLE next edge, divider cleared, no partial step.
  - dir_cmd opposite to dir_q -> DWELL, divider cleared.
  - enable=0 -> IDLE.
- DWELL:
  - Coils hold table[index]; counts DWELL_CYC cycles; no steps.
  - On exit, samples dir_cmd: valid direction -> RUN with dir_q <= dir_cmd; stop -> IDLE.
  - DWELL always completes unless enable=0, which forces IDLE immediately.
- Position arithmetic (unsigned 16-bit):
  - Right step at pos=POS_MAX-1 -> 0.
  - Left step at pos=0 -> POS_MAX-1.
- pos_load:
  - pos <= pos_load_val, clamped to POS_MAX-1 if pos_load_val >= POS_MAX.
  - Wins over a coincident step: pos takes the loaded value. Coil index still advances and step_pulse still fires.
- Legality: dir_cmd 2'b11 treated as stop, never as motion.
- moving is registered; high iff state==RUN.
- enable=0 while in RUN/DWELL: coils=0000 on the next edge; pos and index retained.

Optional Feature:
- Macro HALF_STEP_EN.
- Defined: 8-entry half-step table, index 0..7: 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001; index wraps mod 8. Each step event moves one half-step and updates pos by 1, so POS_MAX must equal the number of half-steps per axis revolution.
- Undefined: 4-entry full-step table as above. Index register is 2 bits instead of 3.

Decomposition:
- Shared package motor_pkg:
  - direction encoding constants DIR_STOP=2'b00, DIR_LEFT=2'b01, DIR_RIGHT=2'b10, also used by the motion controller.
  - FSM state encoding IDLE/RUN/DWELL.
  - Coil lookup tables, full and half.
- One sub-module: step_rate_divider.
  - Parameterised by STEP_DIV; clear input; terminal-count tick output.
  - Instantiated once for the step timer. The dwell counter stays inline.

Test Plan (STEP_DIV=4, DWELL_CYC=3, POS_MAX=360 unless stated):
- Reset then idle: rst pulse mid-cycle -> coils=0000, pos=0, step_pulse=0 immediately (async). After release with enable=1, dir_cmd=00 -> coils=1100 held, no step_pulse over 50 cycles.
- Right run: enable=1, dir_cmd=10 for 17 cycles -> step_pulse at cycles 4, 8, 12, 16; pos=4; coils sequence 0110, 0011, 1001, 1100.
- Wrap: pos_load_val=359 loaded, dir_cmd=10 -> pos 0 after one step. Then pos_load_val=0, dir_cmd=01 -> pos 359 after one step. Then pos_load_val=500 -> pos=359 (clamp).
- Reversal: running right, dir_cmd switches to 01 -> exactly 3 DWELL cycles with coils frozen, moving=0. Then RUN left; first left step 4 cycles later, pos decrements.
- Stop/disable: running, dir_cmd=11 -> IDLE next edge, no further step_pulse. enable=0 while running -> coils=0000, pos unchanged. Re-enable -> coils restore the pre-disable pattern.
- Coincidence: pos_load=1 with pos_load_val=90 on a terminal-count edge -> pos=90, step_pulse=1, coil index advanced.
